// File: rtl/multicycle_adder.sv
// Sequential adder: adds two WIDTH-bit operands plus carry-in, CHUNK bits per
// clock, with the carry registered between slices and a start/busy/done handshake.
module multicycle_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] work_r;
  logic             carry_r;
  logic [IDXW-1:0]  idx_r;

  logic [CHUNK-1:0] a_chunk_s;
  logic [CHUNK-1:0] b_chunk_s;
  logic [CHUNK:0]   chunk_s;
  logic [WIDTH-1:0] work_next_s;
  logic             last_s;
  logic             ovf_s;

  // One CHUNK-wide slice of the add, merged into a copy of the working sum
  always_comb begin
    a_chunk_s   = a_r[idx_r*CHUNK +: CHUNK];
    b_chunk_s   = b_r[idx_r*CHUNK +: CHUNK];
    chunk_s     = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_r};
    work_next_s = work_r;
    work_next_s[idx_r*CHUNK +: CHUNK] = chunk_s[CHUNK-1:0];
    last_s      = (idx_r == IDXW'(NCHUNK - 1));
    ovf_s       = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (work_next_s[WIDTH-1] != a_r[WIDTH-1]);
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      work_r   <= '0;
      carry_r  <= 1'b0;
      idx_r    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= A;
            b_r     <= B;
            carry_r <= cin;
            idx_r   <= '0;
            work_r  <= '0;
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          work_r  <= work_next_s;
          carry_r <= chunk_s[CHUNK];
          idx_r   <= idx_r + IDXW'(1);
          if (last_s) begin
            sum      <= work_next_s;
            cout     <= chunk_s[CHUNK];
            overflow <= ovf_s;
            busy     <= 1'b0;
            done     <= 1'b1;
            state_r  <= DONE;
          end else begin
            busy    <= 1'b1;
            state_r <= RUN;
          end
        end
        DONE: begin
          // back-to-back start is accepted without an IDLE cycle
          if (start) begin
            a_r     <= A;
            b_r     <= B;
            carry_r <= cin;
            idx_r   <= '0;
            work_r  <= '0;
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/multicycle_adder.md
Name: multicycle_adder

Overview:
- Parametrised, sequential successor to the 2-bit carry-in adder.
- Adds two WIDTH-bit operands plus a carry-in, processing CHUNK bits per clock.
- The carry is registered between cycles, so a narrow adder slice serves wide operands.
- Uses a start/busy/done handshake. Sits in the lab datapath where area matters more than latency.

Parameters:
WIDTH  8  operand and sum width in bits; must be a multiple of CHUNK
CHUNK  2  bits added per clock cycle; NCHUNK = WIDTH/CHUNK cycles per operation, NCHUNK >= 1

Ports:
clk       input   1      rising-edge clock
rst       input   1      asynchronous, active-high reset
start     input   1      request; sampled on clk rising edge
A         input   WIDTH  operand A; captured when start is accepted
B         input   WIDTH  operand B; captured when start is accepted
cin       input   1      carry-in; captured when start is accepted
busy      output  1      high while an operation is in progress
done      output  1      one-cycle pulse: result outputs updated this cycle
sum       output  WIDTH  registered result, low WIDTH bits of A+B+cin
cout      output  1      registered carry-out of the full-width add
overflow  output  1      registered two's-complement overflow flag

Behaviour:
- Reset (asynchronous, rst=1): state IDLE; busy=0, done=0, sum=0, cout=0, overflow=0. Chunk index, carry and operand registers are all cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: capture A, B, cin into internal registers; carry<=cin, idx<=0; go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1), at each edge:
  - Compute the chunk sum: A_r[idx*CHUNK +: CHUNK] + B_r[idx*CHUNK +: CHUNK] + carry, a (CHUNK+1)-bit result.
  - Write its low CHUNK bits into the working sum register at the same slice.
  - carry <= MSB of the chunk sum; idx <= idx+1.
  - When idx = NCHUNK-1: go to DONE. On that same edge, load the sum output from the completed working register, cout from the final carry, and overflow = (A_r[W-1]==B_r[W-1]) && (final sum[W-1] != A_r[W-1]).
- DONE: lasts exactly one cycle with done=1, busy=0.
  - start=1 at the DONE edge is accepted (back-to-back): capture operands and go to RUN.
  - Otherwise go to IDLE.
- Latency:
  - start accepted at edge k: busy=1 from after edge k until after edge k+NCHUNK.
  - Results change at edge k+NCHUNK; done=1 during the cycle after edge k+NCHUNK.
  - Throughput is one operation per NCHUNK+1 cycles.
- Result holding: sum, cout and overflow change only on the final RUN edge. They hold between operations and never show partial chunks.
- start while in RUN: ignored. Operands are not re-captured and the operation is unaffected.
- A, B and cin may change freely after capture without affecting the result.
- Wrap-around: sum is modulo 2^WIDTH and the carry-out appears on cout. For example, all-ones + 1 gives sum=0, cout=1.
- NCHUNK=1 (CHUNK=WIDTH): RUN lasts one cycle. Latency is still 1 edge to the result, then DONE.
- Reset mid-operation: abort immediately. No done pulse; outputs return to 0.
- All arithmetic is unsigned internally. overflow is the only signed interpretation.

Test Plan (WIDTH=8, CHUNK=2, NCHUNK=4):
- Reset then idle: assert rst, release, start=0 for 5 cycles -> busy=0, done=0, sum=00000000, cout=0, overflow=0 throughout.
- Basic add with carry chain: A=8'h0F, B=8'h01, cin=0, start pulse -> busy high 4 cycles, then done pulse with sum=8'h10, cout=0, overflow=0. done appears exactly 4 edges after the start edge.
- Wrap-around and carry-in: A=8'hFF, B=8'h00, cin=1 -> sum=8'h00, cout=1, overflow=0. Also A=8'hFF, B=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Signed overflow: A=8'h7F, B=8'h01, cin=0 -> sum=8'h80, cout=0, overflow=1. Also A=8'h80, B=8'h80 -> sum=8'h00, cout=1, overflow=1.
- Handshake robustness:
  - Start A=8'h11, B=8'h22. Then change A/B to 8'hAA and pulse start twice during RUN -> result sum=8'h33; the extra starts are ignored.
  - start held high at the DONE edge with A=8'h05, B=8'h03 -> second operation begins without an IDLE cycle; next done gives sum=8'h08.
- Reset mid-operation: start A=8'hF0, B=8'h0F; assert rst after 2 RUN cycles -> busy=0, sum=0, no done pulse. A subsequent start A=8'h01, B=8'h01 completes with sum=8'h02.
